// File: rtl/misao.sv
// MISA-O accumulator CPU: one program byte fetched per cycle, up to two nibbles decoded per cycle.
// LD/ST suspend nibble decoding for a single memory data cycle addressed by RB.
module misao (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_enable_read,
    output logic        mem_enable_write,
    input  logic [7:0]  mem_data_in,
    output logic [14:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_data_out,
    output logic [15:0] test_data,
    output logic        test_carry
);

    typedef enum logic [1:0] {PH_OPC, PH_IMM, PH_XOP, PH_CFG} phase_e;
    typedef enum logic [1:0] {CYC_FETCH, CYC_LD, CYC_ST} cycle_e;

    typedef struct packed {
        logic [15:0] acc;
        logic [15:0] rb;
        logic        c;
        logic [7:0]  cfg;
        phase_e      phase;
        logic [3:0]  op;
        logic [1:0]  wsel;
        logic [1:0]  cnt;
        logic [15:0] imm;
    } core_t;

    typedef struct packed {
        core_t  core;
        cycle_e req;
    } step_t;

    core_t       core_q, core_d;
    cycle_e      cycle_q, cycle_d;
    logic [15:0] pc_q, pc_d;
    step_t       s0, s1;

    function automatic logic [15:0] width_mask(input logic [1:0] wsel);
        case (wsel)
            2'b00:   return 16'h000F;
            2'b01:   return 16'h00FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [1:0] last_nib(input logic [1:0] wsel);
        case (wsel)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Advance the decoder by one nibble; req flags an LD/ST that ends this cycle's decoding.
    function automatic step_t step(input core_t s, input logic [3:0] nib);
        step_t       r;
        logic [15:0] mask;
        logic [15:0] imm;
        logic [16:0] sum;
        r      = '{core: s, req: CYC_FETCH};
        mask   = width_mask(s.wsel);
        imm    = s.imm | ({12'h000, nib} << {s.cnt, 2'b00});
        sum    = {1'b0, s.acc & mask} + {1'b0, imm & mask};
        case (s.phase)
            PH_OPC: begin
                mask = width_mask(s.cfg[1:0]);
                case (nib)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        r.core.phase = PH_IMM;
                        r.core.op    = nib;
                        r.core.wsel  = s.cfg[1:0];
                        r.core.cnt   = 2'd0;
                        r.core.imm   = 16'h0000;
                    end
                    4'h6: begin
                        r.core.acc = (s.acc & ~mask) | ((s.acc << 1) & mask);
                        r.core.c   = |(s.acc & (mask ^ (mask >> 1)));
                    end
                    4'h7: begin
                        r.core.acc = (s.acc & ~mask) | ((s.acc & mask) >> 1);
                        r.core.c   = s.acc[0];
                    end
                    4'h8: begin
                        r.core.acc = s.rb;
                        r.core.rb  = s.acc;
                    end
                    4'h9:    r.req = CYC_LD;
                    4'hA:    r.req = CYC_ST;
                    4'hF:    r.core.phase = PH_XOP;
                    default: ;
                endcase
            end
            PH_IMM: begin
                r.core.imm = imm;
                r.core.cnt = s.cnt + 2'd1;
                if (s.cnt == last_nib(s.wsel)) begin
                    r.core.phase = PH_OPC;
                    case (s.op)
                        4'h1: begin
                            r.core.acc = imm;
                            r.core.c   = 1'b0;
                        end
                        4'h2: begin
                            r.core.acc = (s.acc & ~mask) | (sum[15:0] & mask);
                            r.core.c   = |(sum & ({1'b0, mask} + 17'd1));
                        end
                        4'h3: begin
                            r.core.acc = (s.acc & ~mask) | (s.acc & imm & mask);
                            r.core.c   = 1'b0;
                        end
                        4'h4: begin
                            r.core.acc = (s.acc & ~mask) | ((s.acc | imm) & mask);
                            r.core.c   = 1'b0;
                        end
                        4'h5: begin
                            r.core.acc = (s.acc & ~mask) | ((s.acc ^ imm) & mask);
                            r.core.c   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            PH_XOP: begin
                r.core.phase = (nib == 4'h1) ? PH_CFG : PH_OPC;
                r.core.cnt   = 2'd0;
                r.core.imm   = 16'h0000;
            end
            default: begin
                r.core.imm = imm;
                r.core.cnt = s.cnt + 2'd1;
                if (s.cnt == 2'd1) begin
                    r.core.cfg   = imm[7:0];
                    r.core.phase = PH_OPC;
                end
            end
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            core_q  <= '0;
            cycle_q <= CYC_FETCH;
            pc_q    <= 16'h0000;
        end else begin
            core_q  <= core_d;
            cycle_q <= cycle_d;
            pc_q    <= pc_d;
        end
    end

    // The high nibble is decoded in the same cycle only when the low nibble did not start LD/ST.
    always_comb begin
        core_d  = core_q;
        cycle_d = CYC_FETCH;
        pc_d    = pc_q;
        s0      = '0;
        s1      = '0;
        case (cycle_q)
            CYC_LD: core_d.acc = {8'h00, mem_data_in};
            CYC_ST: ;
            default: begin
                s0     = step(core_q, pc_q[0] ? mem_data_in[7:4] : mem_data_in[3:0]);
                core_d = s0.core;
                pc_d   = pc_q + 16'd1;
                if (s0.req != CYC_FETCH) begin
                    cycle_d = s0.req;
                end else if (!pc_q[0]) begin
                    s1      = step(s0.core, mem_data_in[7:4]);
                    core_d  = s1.core;
                    pc_d    = pc_q + 16'd2;
                    cycle_d = s1.req;
                end
            end
        endcase
    end

    always_comb begin
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
        mem_addr         = 15'h0000;
        mem_data_out     = 8'h00;
        if (rst) begin
            case (cycle_q)
                CYC_LD: begin
                    mem_enable_read = 1'b1;
                    mem_addr        = core_q.rb[14:0];
                end
                CYC_ST: begin
                    mem_enable_write = 1'b1;
                    mem_rw           = 1'b1;
                    mem_addr         = core_q.rb[14:0];
                    mem_data_out     = core_q.acc[7:0];
                end
                default: begin
                    mem_enable_read = 1'b1;
                    mem_addr        = pc_q[15:1];
                end
            endcase
        end
    end

    assign test_data  = core_q.acc;
    assign test_carry = core_q.c;

endmodule

// File: tb/tb_misao.sv
// Directed bench for misao: one program image, table of post-fetch ACC/C checks, plus
// hand-written LD/ST, shift and mid-instruction reset sequences.
module tb_misao;

    typedef struct {
        logic [14:0] read_addr;
        logic [15:0] acc;
        logic        c;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable_read, mem_enable_write, mem_rw, test_carry;
    logic [7:0]  mem_data_in, mem_data_out;
    logic [14:0] mem_addr;
    logic [15:0] test_data;

    logic [7:0]  mem [0:32767];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          write_count  = 0;
    logic [14:0] last_wr_addr = 15'h0000;
    logic [7:0]  last_wr_data = 8'h00;

    misao dut (
        .clk(clk),
        .rst(rst),
        .mem_enable_read(mem_enable_read),
        .mem_enable_write(mem_enable_write),
        .mem_data_in(mem_data_in),
        .mem_addr(mem_addr),
        .mem_rw(mem_rw),
        .mem_data_out(mem_data_out),
        .test_data(test_data),
        .test_carry(test_carry)
    );

    always #5 clk = ~clk;

    // Program ROM with the most recent store overlaid, so LD sees what ST wrote.
    always_comb begin
        if (write_count != 0 && mem_addr == last_wr_addr)
            mem_data_in = last_wr_data;
        else
            mem_data_in = mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_enable_write) begin
            write_count  <= write_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_data_out;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_fetch(input logic [14:0] addr);
        int  n = 0;
        bit  found = 0;
        while (!found && n < 64) begin
            if (mem_enable_read && !mem_rw && mem_addr == addr) found = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL fetch_timeout: no fetch seen, expected fetch of byte 0x%0h", addr);
        end
    endtask

    // Byte 2/6/11 hold XOP then sub-op 1 in execution order, i.e. low nibble F, high nibble 1.
    task automatic applyStimulus();
        logic [7:0] prog [0:31];
        prog = '{8'h00, 8'h51, 8'h1F, 8'h0D, 8'hB1, 8'h0A, 8'h1F, 8'h0E,
                 8'h41, 8'h23, 8'h01, 8'h1F, 8'h0D, 8'h01, 8'h2F, 8'h20,
                 8'h03, 8'hF0, 8'hE1, 8'h10, 8'h00, 8'h01, 8'h18, 8'h5A,
                 8'h00, 8'h1A, 8'h00, 8'h00, 8'h79, 8'h07, 8'h21, 8'h33};
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = prog[i];
    endtask

    initial begin
        vec_t vecs [10];
        vecs[0] = '{15'd1,  16'h0005, 1'b0, "ldi_ul"};
        vecs[1] = '{15'd5,  16'h00AB, 1'b0, "ldi_lk8"};
        vecs[2] = '{15'd10, 16'h1234, 1'b0, "ldi_lk16"};
        vecs[3] = '{15'd14, 16'h00F0, 1'b0, "ldi_lk8_zext"};
        vecs[4] = '{15'd15, 16'h0010, 1'b1, "addi_lk8_carry"};
        vecs[5] = '{15'd17, 16'h0000, 1'b0, "andi_lk8"};
        vecs[6] = '{15'd21, 16'h0100, 1'b0, "ldi_rb_value"};
        vecs[7] = '{15'd22, 16'h0000, 1'b0, "swp"};
        vecs[8] = '{15'd24, 16'h005A, 1'b0, "ldi_st_value"};
        vecs[9] = '{15'd27, 16'h0000, 1'b0, "ldi_zero"};

        applyStimulus();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_acc", test_data, 16'h0000);
        checkOutput("reset_c", test_carry, 1'b0);
        checkOutput("reset_rd", mem_enable_read, 1'b0);
        checkOutput("reset_wr", mem_enable_write, 1'b0);
        checkOutput("reset_addr", mem_addr, 15'h0000);
        checkOutput("reset_dout", mem_data_out, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wait_fetch(vecs[i].read_addr);
            @(negedge clk);
            checkOutput({vecs[i].name, "_acc"}, test_data, vecs[i].acc);
            checkOutput({vecs[i].name, "_c"}, test_carry, vecs[i].c);
        end

        checkOutput("st_count", write_count, 1);
        checkOutput("st_addr", last_wr_addr, 15'h0100);
        checkOutput("st_data", last_wr_data, 8'h5A);

        @(negedge clk);
        checkOutput("ld_rd", mem_enable_read, 1'b1);
        checkOutput("ld_rw", mem_rw, 1'b0);
        checkOutput("ld_wr", mem_enable_write, 1'b0);
        checkOutput("ld_addr", mem_addr, 15'h0100);
        @(negedge clk);
        checkOutput("ld_acc", test_data, 16'h005A);
        checkOutput("ld_resume_addr", mem_addr, 15'd28);
        @(negedge clk);
        checkOutput("shr1_acc", test_data, 16'h002D);
        checkOutput("shr1_c", test_carry, 1'b0);
        @(negedge clk);
        checkOutput("shr2_acc", test_data, 16'h0016);
        checkOutput("shr2_c", test_carry, 1'b1);

        wait_fetch(15'd31);
        checkOutput("partial_ldi_acc", test_data, 16'h0016);
        rst = 1'b0;
        #1;
        checkOutput("midrst_rd", mem_enable_read, 1'b0);
        checkOutput("midrst_addr", mem_addr, 15'h0000);
        @(negedge clk);
        checkOutput("midrst_acc", test_data, 16'h0000);
        checkOutput("midrst_c", test_carry, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("restart_rd", mem_enable_read, 1'b1);
        checkOutput("restart_addr", mem_addr, 15'h0000);
        wait_fetch(15'd1);
        @(negedge clk);
        checkOutput("restart_ldi_ul", test_data, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
